// File: rtl/collision_pkg.sv
// Shared types and collision-box ROMs for the runner-game collision scanner.
package collision_pkg;
  localparam int BOX_W = 12;

  typedef enum logic [1:0] {
    KIND_CACTUS_SMALL = 2'd0,
    KIND_CACTUS_LARGE = 2'd1,
    KIND_PTERODACTYL  = 2'd2,
    KIND_NONE         = 2'd3
  } obs_kind_e;

  typedef enum logic [1:0] {ST_IDLE, ST_OUTER, ST_INNER, ST_FINISH} scan_state_e;

  typedef struct packed {
    logic signed [BOX_W-1:0] x;
    logic signed [BOX_W-1:0] y;
    logic signed [BOX_W-1:0] w;
    logic signed [BOX_W-1:0] h;
  } collision_box_t;

  localparam int TREX_N   = 6;
  localparam int CACTUS_N = 3;
  localparam int PTERO_N  = 5;

  localparam logic signed [BOX_W-1:0] B_ONE = BOX_W'(1);
  localparam logic signed [BOX_W-1:0] B_TWO = BOX_W'(2);

  function automatic collision_box_t mk_box(input int x, input int y, input int w, input int h);
    return '{x: BOX_W'(x), y: BOX_W'(y), w: BOX_W'(w), h: BOX_W'(h)};
  endfunction

  localparam collision_box_t TREX [TREX_N] = '{
    mk_box(22, 0, 17, 16), mk_box(1, 18, 30, 9), mk_box(10, 35, 14, 8),
    mk_box(1, 24, 29, 5),  mk_box(5, 30, 21, 4), mk_box(9, 34, 15, 4)};
  localparam collision_box_t TREX_DUCK = mk_box(1, 18, 55, 25);
  localparam collision_box_t CACTUS_SMALL [CACTUS_N] = '{
    mk_box(0, 7, 5, 27), mk_box(4, 0, 6, 34), mk_box(10, 4, 7, 14)};
  localparam collision_box_t CACTUS_LARGE [CACTUS_N] = '{
    mk_box(0, 12, 7, 38), mk_box(8, 0, 7, 49), mk_box(13, 10, 10, 38)};
  localparam collision_box_t PTERODACTYL [PTERO_N] = '{
    mk_box(15, 15, 16, 5), mk_box(18, 21, 24, 6), mk_box(2, 14, 4, 3),
    mk_box(6, 10, 4, 7),   mk_box(10, 8, 6, 9)};

  function automatic collision_box_t trex_box(input logic duck, input logic [2:0] idx);
    collision_box_t b;
    b = '0;
    if (duck) b = TREX_DUCK;
    else if (idx < 3'(TREX_N)) b = TREX[idx];
    return b;
  endfunction

  function automatic collision_box_t obs_box(input obs_kind_e kind, input logic [2:0] idx);
    collision_box_t b;
    b = '0;
    case (kind)
      KIND_CACTUS_SMALL: if (idx < 3'd3) b = CACTUS_SMALL[idx[1:0]];
      KIND_CACTUS_LARGE: if (idx < 3'd3) b = CACTUS_LARGE[idx[1:0]];
      KIND_PTERODACTYL:  if (idx < 3'd5) b = PTERODACTYL[idx];
      default:           b = '0;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] obs_box_count(input obs_kind_e kind);
    case (kind)
      KIND_CACTUS_SMALL, KIND_CACTUS_LARGE: return 3'd3;
      KIND_PTERODACTYL:                     return 3'd5;
      default:                              return 3'd0;
    endcase
  endfunction

  // Unit-cactus width of box i, used to stretch grouped cacti.
  function automatic logic signed [BOX_W-1:0] cactus_w(input obs_kind_e kind, input logic [1:0] i);
    return (kind == KIND_CACTUS_LARGE) ? CACTUS_LARGE[i].w : CACTUS_SMALL[i].w;
  endfunction
endpackage

// File: rtl/collision_scanner_box_overlap.sv
// Combinational strict-overlap test of two boxes; touching edges do not collide.
module box_overlap
  import collision_pkg::*;
(
  input  collision_box_t a,
  input  collision_box_t b,
  output logic           overlap
);
  // One guard bit so origin+size never wraps.
  function automatic logic signed [BOX_W:0] sx(input logic signed [BOX_W-1:0] v);
    return {v[BOX_W-1], v};
  endfunction

  logic signed [BOX_W:0] ax, ay, aw, ah, bx, by, bw, bh;

  always_comb begin
    ax = sx(a.x); ay = sx(a.y); aw = sx(a.w); ah = sx(a.h);
    bx = sx(b.x); by = sx(b.y); bw = sx(b.w); bh = sx(b.h);
    overlap = (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  end
endmodule

// File: rtl/collision_scanner.sv
// Per-frame collision engine: snapshots T-rex and obstacles on start, runs a
// cheap outer-box pass per slot, then a box-pair scan only where outer boxes meet.
//   state  | meaning
//   IDLE   | waiting for start
//   OUTER  | outer-box test of slot k
//   INNER  | detailed pair (t,o) of slot k
//   FINISH | one-cycle done pulse
module collision_scanner
  import collision_pkg::*;
#(
  parameter int MAX_OBSTACLES = 2,
  parameter int TREX_BOXES    = 6,
  parameter int OBS_BOXES     = 5,
  parameter int COORD_W       = 11,
  localparam int IW = (MAX_OBSTACLES > 1) ? $clog2(MAX_OBSTACLES) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 ducking,
  input  logic [9:0]                           trex_x,
  input  logic [9:0]                           trex_y,
  input  logic [9:0]                           trex_w,
  input  logic [9:0]                           trex_h,
  input  logic [MAX_OBSTACLES-1:0]             obs_valid,
  input  logic [MAX_OBSTACLES-1:0][1:0]        obs_kind,
  input  logic [MAX_OBSTACLES-1:0][COORD_W-1:0] obs_x,
  input  logic [MAX_OBSTACLES-1:0][9:0]        obs_y,
  input  logic [MAX_OBSTACLES-1:0][9:0]        obs_w,
  input  logic [MAX_OBSTACLES-1:0][9:0]        obs_h,
  input  logic [MAX_OBSTACLES-1:0][1:0]        obs_size,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 hit,
  output logic [IW-1:0]                        hit_index
);
  scan_state_e state, state_n;
  logic [IW-1:0] k, k_n, hit_index_n;
  logic [2:0] t, t_n, o, o_n, t_last, o_last, o_cnt;
  logic hit_n, load, k_last, valid_k, outer_hit, inner_hit;

  logic duck_s;
  logic [9:0] tx_s, ty_s, tw_s, th_s;
  logic [MAX_OBSTACLES-1:0] valid_s;
  logic [MAX_OBSTACLES-1:0][1:0] kind_s, size_s;
  logic [MAX_OBSTACLES-1:0][COORD_W-1:0] x_s;
  logic [MAX_OBSTACLES-1:0][9:0] y_s, w_s, h_s;

  obs_kind_e kind_k;
  logic signed [BOX_W-1:0] tx, ty, ox, oy, wtot;
  collision_box_t outer_a, outer_b, inner_a, inner_b, tb, ob;

  always_ff @(posedge clk) begin
    if (load) begin
      duck_s <= ducking;
      tx_s <= trex_x; ty_s <= trex_y; tw_s <= trex_w; th_s <= trex_h;
      valid_s <= obs_valid; kind_s <= obs_kind; size_s <= obs_size;
      x_s <= obs_x; y_s <= obs_y; w_s <= obs_w; h_s <= obs_h;
    end
  end

  assign kind_k  = obs_kind_e'(kind_s[k]);
  assign valid_k = valid_s[k] && (kind_k != KIND_NONE);
  assign k_last  = (k == IW'(MAX_OBSTACLES - 1));
  assign tx      = $signed(BOX_W'(tx_s));
  assign ty      = $signed(BOX_W'(ty_s));
  assign ox      = BOX_W'($signed(x_s[k]));
  assign oy      = $signed(BOX_W'(y_s[k]));
  assign wtot    = $signed(BOX_W'(w_s[k]) * BOX_W'(size_s[k]));
  assign t_last  = duck_s ? 3'd0 : 3'(TREX_BOXES - 1);

  always_comb begin
    o_cnt = obs_box_count(kind_k);
    if (o_cnt > 3'(OBS_BOXES)) o_cnt = 3'(OBS_BOXES);
    o_last = o_cnt - 3'd1;

    outer_a = '{x: tx + B_ONE, y: ty + B_ONE,
                w: $signed(BOX_W'(tw_s)) - B_TWO, h: $signed(BOX_W'(th_s)) - B_TWO};
    outer_b = '{x: ox + B_ONE, y: oy + B_ONE,
                w: wtot - B_TWO, h: $signed(BOX_W'(h_s[k])) - B_TWO};

    tb = trex_box(duck_s, t);
    ob = obs_box(kind_k, o);
    // Grouped cacti: middle box stretches, last box moves to the right edge.
    if ((kind_k == KIND_CACTUS_SMALL || kind_k == KIND_CACTUS_LARGE) && size_s[k] > 2'd1) begin
      if (o == 3'd1) ob.w = wtot - cactus_w(kind_k, 2'd0) - cactus_w(kind_k, 2'd2);
      if (o == 3'd2) ob.x = wtot - cactus_w(kind_k, 2'd2);
    end
    inner_a = tb;
    inner_a.x = tx + tb.x;
    inner_a.y = ty + tb.y;
    inner_b = ob;
    inner_b.x = ox + ob.x;
    inner_b.y = oy + ob.y;
  end

  box_overlap u_outer (.a(outer_a), .b(outer_b), .overlap(outer_hit));
  box_overlap u_inner (.a(inner_a), .b(inner_b), .overlap(inner_hit));

  always_comb begin
    state_n     = state;
    k_n         = k;
    t_n         = t;
    o_n         = o;
    hit_n       = hit;
    hit_index_n = hit_index;
    load        = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        load        = 1'b1;
        hit_n       = 1'b0;
        hit_index_n = '0;
        k_n         = '0;
        state_n     = ST_OUTER;
      end
      ST_OUTER: begin
        if (valid_k && outer_hit) begin
          t_n     = 3'd0;
          o_n     = 3'd0;
          state_n = ST_INNER;
        end else if (k_last) state_n = ST_FINISH;
        else k_n = k + 1'b1;
      end
      ST_INNER: begin
        if (inner_hit) begin
          hit_n       = 1'b1;
          hit_index_n = k;
          state_n     = ST_FINISH;
        end else if (o == o_last) begin
          o_n = 3'd0;
          if (t == t_last) begin
            if (k_last) state_n = ST_FINISH;
            else begin
              k_n     = k + 1'b1;
              state_n = ST_OUTER;
            end
          end else t_n = t + 3'd1;
        end else o_n = o + 3'd1;
      end
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      k <= '0; t <= 3'd0; o <= 3'd0;
      hit <= 1'b0; hit_index <= '0;
    end else begin
      state <= state_n;
      k <= k_n; t <= t_n; o <= o_n;
      hit <= hit_n; hit_index <= hit_index_n;
    end
  end

  assign busy = (state == ST_OUTER) || (state == ST_INNER);
  assign done = (state == ST_FINISH);
endmodule

// File: tb/tb_collision_scanner.sv
// Scoreboarded bench for collision_scanner with an independent game-geometry model.
module tb_collision_scanner;
  logic clk = 1'b0;
  logic rst, start, ducking;
  logic [9:0] trex_x, trex_y, trex_w, trex_h;
  logic [1:0] obs_valid;
  logic [1:0][1:0] obs_kind, obs_size;
  logic [1:0][10:0] obs_x;
  logic [1:0][9:0] obs_y, obs_w, obs_h;
  logic busy, done, hit;
  logic [0:0] hit_index;

  collision_scanner dut (
    .clk(clk), .rst(rst), .start(start), .ducking(ducking),
    .trex_x(trex_x), .trex_y(trex_y), .trex_w(trex_w), .trex_h(trex_h),
    .obs_valid(obs_valid), .obs_kind(obs_kind), .obs_x(obs_x),
    .obs_y(obs_y), .obs_w(obs_w), .obs_h(obs_h), .obs_size(obs_size),
    .busy(busy), .done(done), .hit(hit), .hit_index(hit_index));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_errors = 0, start_cyc = 0;

  typedef struct { bit h; int idx; int lat; } exp_t;
  exp_t sb[$];

  int trex_t [6][4] = '{'{22,0,17,16}, '{1,18,30,9}, '{10,35,14,8},
                        '{1,24,29,5}, '{5,30,21,4}, '{9,34,15,4}};
  int duck_t [4]    = '{1,18,55,25};
  int cs_t [3][4]   = '{'{0,7,5,27}, '{4,0,6,34}, '{10,4,7,14}};
  int cl_t [3][4]   = '{'{0,12,7,38}, '{8,0,7,49}, '{13,10,10,38}};
  int pt_t [5][4]   = '{'{15,15,16,5}, '{18,21,24,6}, '{2,14,4,3}, '{6,10,4,7}, '{10,8,6,9}};

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit ovl(input int ax, ay, aw, ah, bx, by, bw, bh);
    return (ax < bx + bw) && (bx < ax + aw) && (ay < by + bh) && (by < ay + ah);
  endfunction

  task automatic get_obs(input int kind, o, w, sz, output int bx, by, bw, bh);
    int row[4];
    int r0w, r2w;
    if (kind == 0) begin row = cs_t[o]; r0w = cs_t[0][2]; r2w = cs_t[2][2]; end
    else if (kind == 1) begin row = cl_t[o]; r0w = cl_t[0][2]; r2w = cl_t[2][2]; end
    else begin row = pt_t[o]; r0w = 0; r2w = 0; end
    bx = row[0]; by = row[1]; bw = row[2]; bh = row[3];
    if (kind < 2 && sz > 1) begin
      if (o == 1) bw = w * sz - r0w - r2w;
      if (o == 2) bx = w * sz - r2w;
    end
  endtask

  task automatic model_scan(output exp_t e);
    int n, tx, ty, ox, oy, ow, sz, kd, ntb, nob;
    int ax, ay, aw, ah, bx, by, bw, bh;
    n = 0; e.h = 0; e.idx = 0;
    tx = int'(trex_x); ty = int'(trex_y);
    for (int k = 0; k < 2; k++) begin
      n++;
      kd = int'(obs_kind[k]); sz = int'(obs_size[k]);
      ox = int'($signed(obs_x[k])); oy = int'(obs_y[k]); ow = int'(obs_w[k]);
      if (obs_valid[k] && kd != 3 &&
          ovl(tx + 1, ty + 1, int'(trex_w) - 2, int'(trex_h) - 2,
              ox + 1, oy + 1, ow * sz - 2, int'(obs_h[k]) - 2)) begin
        ntb = ducking ? 1 : 6;
        nob = (kd == 2) ? 5 : 3;
        for (int t = 0; t < ntb; t++)
          for (int o = 0; o < nob; o++) begin
            n++;
            if (ducking) begin ax = duck_t[0]; ay = duck_t[1]; aw = duck_t[2]; ah = duck_t[3]; end
            else begin ax = trex_t[t][0]; ay = trex_t[t][1]; aw = trex_t[t][2]; ah = trex_t[t][3]; end
            get_obs(kd, o, ow, sz, bx, by, bw, bh);
            if (ovl(tx + ax, ty + ay, aw, ah, ox + bx, oy + by, bw, bh)) begin
              e.h = 1; e.idx = k; e.lat = n + 1;
              return;
            end
          end
      end
    end
    e.lat = n + 1;
  endtask

  task automatic set_obs(input int k, input bit v, input int kind, x, y, w, h, sz);
    obs_valid[k] = v; obs_kind[k] = 2'(kind); obs_x[k] = 11'(x);
    obs_y[k] = 10'(y); obs_w[k] = 10'(w); obs_h[k] = 10'(h); obs_size[k] = 2'(sz);
  endtask

  task automatic start_scan(input bit push);
    exp_t e;
    model_scan(e);
    if (push) sb.push_back(e);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", int'(busy), 1);
  endtask

  task automatic finish_scan();
    exp_t e;
    while (!done && (cyc - start_cyc) < 200) @(negedge clk);
    check_val("done_seen", int'(done), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val("latency", cyc - start_cyc, e.lat);
      check_val("hit", int'(hit), int'(e.h));
      check_val("hit_index", int'(hit_index), e.idx);
    end
    @(negedge clk);
    check_val("done_one_cycle", int'(done), 0);
    check_val("busy_after_done", int'(busy), 0);
  endtask

  task automatic run_scan();
    start_scan(1'b1);
    finish_scan();
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check_val(tag, seen, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ducking = 1'b0;
    trex_x = 10'd50; trex_y = 10'd93; trex_w = 10'd44; trex_h = 10'd47;
    set_obs(0, 0, 0, 0, 0, 0, 0, 1);
    set_obs(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_hit", int'(hit), 0);
    check_val("rst_hit_index", int'(hit_index), 0);
    rst = 1'b0;
    @(negedge clk);

    // far cactus, then the same cactus overlapping
    set_obs(0, 1, 0, 300, 105, 17, 35, 1);
    run_scan();
    set_obs(0, 1, 0, 60, 105, 17, 35, 1);
    run_scan();

    // ducking under a pterodactyl in slot 1
    set_obs(0, 0, 0, 60, 105, 17, 35, 1);
    set_obs(1, 1, 2, 60, 50, 46, 40, 1);
    ducking = 1'b1;
    run_scan();
    ducking = 1'b0;

    // overlapping cactus in slot 1, masked then unmasked
    set_obs(0, 1, 0, 300, 105, 17, 35, 1);
    set_obs(1, 0, 0, 60, 105, 17, 35, 1);
    run_scan();
    obs_valid = 2'b10;
    run_scan();

    // large cactus group; second start during the scan must be ignored
    set_obs(0, 1, 1, 60, 90, 34, 50, 3);
    set_obs(1, 0, 0, 0, 0, 0, 0, 1);
    start_scan(1'b1);
    @(negedge clk);
    obs_valid = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_scan();
    watch_no_done("ignored_start_no_done", 8);
    check_val("hit_held", int'(hit), 1);

    // negative x: only the stretched middle box reaches the T-rex
    set_obs(0, 1, 1, -40, 90, 34, 50, 3);
    run_scan();
    // kind code 3 behaves as empty
    set_obs(0, 1, 3, 60, 105, 17, 35, 1);
    run_scan();

    // random frames, inputs scrambled mid-scan
    for (int i = 0; i < 24; i++) begin
      ducking = 1'($urandom_range(1, 0));
      for (int k = 0; k < 2; k++)
        set_obs(k, 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(260, 0)) - 60, int'($urandom_range(140, 40)),
                int'($urandom_range(50, 5)), int'($urandom_range(50, 10)),
                int'($urandom_range(3, 1)));
      start_scan(1'b1);
      obs_x = 22'($urandom);
      obs_valid = 2'($urandom);
      ducking = ~ducking;
      finish_scan();
    end

    // reset while in INNER aborts the scan
    ducking = 1'b0;
    set_obs(0, 1, 0, 60, 105, 17, 35, 1);
    set_obs(1, 0, 0, 0, 0, 0, 0, 1);
    start_scan(1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_mid_busy", int'(busy), 0);
    check_val("rst_mid_hit", int'(hit), 0);
    watch_no_done("rst_mid_no_done", 12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
